matmul_feeder: RTL and testbench
================================

Name: matmul_feeder

Overview:
- Front-end sequencer for the column-wise 8x8 int8 matrix-vector MAC array.
- Buffers an 8x8 signed int8 matrix (stored by column) and an 8-element int8 vector.
- On start, streams one column plus its matching vector element per cycle into the array, then waits for the array's packed 256-bit result.
- Captures the result and presents it on a valid/ready output port to the downstream consumer.

Parameters:
- N, 8, matrix dimension: columns streamed, vector elements, result lanes.
- DW, 8, element width in bits (signed).
- ACC_W, 32, result lane width in bits (signed).
- TIMEOUT, 64, cycles allowed in WAIT before abort; used only with the optional feature.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- wr_en_i  in  1  buffer write strobe.
- wr_sel_i  in  1  0 = matrix column write, 1 = vector write.
- wr_addr_i  in  3  column index for matrix writes; ignored for vector writes.
- wr_data_i  in  N*DW  column (element r in bits [8r+7:8r]) or packed vector (element k in bits [8k+7:8k]).
- start_i  in  1  start request.
- busy_o  out  1  high whenever state is not IDLE.
- done_o  out  1  one-cycle pulse when the result handshake completes.
- err_o  out  1  one-cycle timeout abort pulse.
- mm_en_o  out  1  array enable.
- mm_valid_o  out  1  beat valid to array.
- mm_col_o  out  N*DW  current column.
- mm_elem_o  out  DW  current vector element.
- mm_valid_i  in  1  array result valid.
- mm_result_i  in  N*ACC_W  packed result; lane r in bits [32r+31:32r].
- res_valid_o  out  1  result valid to consumer.
- res_ready_i  in  1  consumer ready.
- res_data_o  out  N*ACC_W  captured result.

Behaviour:
- Reset (rst_i high at a clock edge):
  - State goes to IDLE; matrix and vector buffers are cleared to 0; beat counter is cleared to 0.
  - All outputs are 0: busy_o, done_o, err_o, mm_en_o, mm_valid_o, mm_col_o, mm_elem_o, res_valid_o, res_data_o.
  - Reset in any state aborts immediately; there is no partial result and no done_o.
- Buffer writes:
  - Accepted only in IDLE. Matrix write: col[wr_addr_i] <= wr_data_i. Vector write: vec <= wr_data_i.
  - Writes in any other state are ignored and the buffers stay unchanged.
- FSM states: IDLE, STREAM, WAIT, HOLD.
- IDLE:
  - start_i = 1 -> STREAM, beat counter k = 0.
  - start_i in other states is ignored (no queuing).
  - If start_i and wr_en_i occur in the same IDLE cycle, the write is applied first, then the start.
- STREAM:
  - All array-side outputs are registered. The first beat appears in the cycle after start is accepted.
  - Beat k: mm_valid_o = 1, mm_col_o = col[k], mm_elem_o = vec element k.
  - Exactly N consecutive beats, no bubbles. After beat N-1 -> WAIT.
  - mm_en_o = 1 from the first beat through the WAIT exit.
- WAIT:
  - mm_valid_o = 0; mm_col_o and mm_elem_o hold their last values.
  - On mm_valid_i = 1: res_data_o <= mm_result_i, res_valid_o <= 1, mm_en_o <= 0, go to HOLD.
  - mm_valid_i in IDLE, STREAM or HOLD is ignored; res_data_o is never overwritten in HOLD.
- HOLD:
  - res_valid_o stays high and res_data_o stays stable until res_ready_i = 1.
  - On handshake: res_valid_o <= 0, done_o pulses for one cycle, go to IDLE. A new start_i is accepted the cycle after return.
  - If res_ready_i is already high when res_valid_o rises, the handshake completes in that first HOLD cycle.
- Arithmetic: the block does none; result lanes pass through as signed 32-bit values unmodified.
- Buffers persist across runs; repeated start_i without new writes recomputes the same data.

Optional Feature:
- Macro: MATMUL_FEEDER_TIMEOUT_EN.
- Defined:
  - A counter runs from 0 on WAIT entry.
  - If TIMEOUT cycles pass without mm_valid_i: err_o pulses for one cycle, mm_en_o <= 0, go to IDLE. res_valid_o stays 0 and done_o does not pulse.
  - mm_valid_i in the same cycle the count expires wins: the result is captured and there is no error.
- Undefined: no counter; WAIT persists indefinitely; err_o is tied to 0.

Test Plan:
1. Identity matrix, vector = 1..8, array model with 3-cycle latency, res_ready_i = 1 -> 8 beats with column k = e_k, lane r = r+1, done_o pulses once, busy_o low next cycle.
2. All matrix and vector elements = -128 -> every lane = 0x00020000 (8*16384); confirms signed pass-through.
3. res_ready_i held low 5 cycles in HOLD -> res_data_o stable, res_valid_o high throughout, done_o only in the handshake cycle; a second mm_valid_i pulse during HOLD does not change the data.
4. start_i and wr_en_i (column 0 = 0xFF..FF) asserted during STREAM -> ignored; beat sequence and result match the pre-start buffers; exactly one run completes.
5. rst_i asserted at beat 4 -> next cycle all outputs are 0, state IDLE, buffers 0; a following start with an unloaded buffer yields an all-zero result.
6. With MATMUL_FEEDER_TIMEOUT_EN and TIMEOUT = 64, array never asserts valid -> err_o pulses 64 cycles after WAIT entry, busy_o falls, done_o stays 0. Without the macro, the block stays in WAIT and err_o stays 0.

Source files
------------

// File: rtl/matmul_feeder.sv
// Column-streaming front end for the 8x8 int8 MAC array: buffers matrix and vector,
// streams N beats, then captures the packed result. Optional WAIT abort: MATMUL_FEEDER_TIMEOUT_EN.
module matmul_feeder #(
  parameter int unsigned N       = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned AW     = $clog2(N)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic               wr_sel_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [N*DW-1:0]    wr_data_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               mm_en_o,
  output logic               mm_valid_o,
  output logic [N*DW-1:0]    mm_col_o,
  output logic [DW-1:0]      mm_elem_o,
  input  logic               mm_valid_i,
  input  logic [N*ACC_W-1:0] mm_result_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [N*ACC_W-1:0] res_data_o
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, HOLD} state_t;

  state_t               state_q;
  logic [N*DW-1:0]      col_q [N];
  logic [N*DW-1:0]      col_d [N];
  logic [N*DW-1:0]      vec_q, vec_d;
  logic [AW-1:0]        k_q, beat_idx;
  logic [N*DW-1:0]      beat_col;
  logic [DW-1:0]        beat_elem;
  logic                 busy_q, done_q, mm_en_q, mm_valid_q, res_valid_q;
  logic [N*DW-1:0]      mm_col_q;
  logic [DW-1:0]        mm_elem_q;
  logic [N*ACC_W-1:0]   res_data_q;

`ifdef MATMUL_FEEDER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt_q;
  logic          err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_comb begin
    col_d = col_q;
    vec_d = vec_q;
    if (state_q == IDLE && wr_en_i) begin
      if (wr_sel_i) vec_d = wr_data_i;
      else          col_d[wr_addr_i] = wr_data_i;
    end
  end

  // Outside IDLE the _d buffers equal the stored ones, so this one mux feeds both the
  // first beat (which must see a same-cycle write) and every following beat.
  always_comb begin
    beat_idx  = (state_q == IDLE) ? '0 : k_q + 1'b1;
    beat_col  = col_d[beat_idx];
    beat_elem = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (AW'(i) == beat_idx) beat_elem = vec_d[i*DW +: DW];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      col_q       <= '{default: '0};
      vec_q       <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mm_en_q     <= 1'b0;
      mm_valid_q  <= 1'b0;
      mm_col_q    <= '0;
      mm_elem_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
`ifdef MATMUL_FEEDER_TIMEOUT_EN
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      col_q  <= col_d;
      vec_q  <= vec_d;
      done_q <= 1'b0;
`ifdef MATMUL_FEEDER_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= STREAM;
            busy_q     <= 1'b1;
            mm_en_q    <= 1'b1;
            mm_valid_q <= 1'b1;
            mm_col_q   <= beat_col;
            mm_elem_q  <= beat_elem;
            k_q        <= '0;
          end
        end
        STREAM: begin
          if (k_q == AW'(N - 1)) begin
            state_q    <= WAIT;
            mm_valid_q <= 1'b0;
            k_q        <= '0;
`ifdef MATMUL_FEEDER_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end else begin
            k_q       <= beat_idx;
            mm_col_q  <= beat_col;
            mm_elem_q <= beat_elem;
          end
        end
        WAIT: begin
          if (mm_valid_i) begin
            res_data_q  <= mm_result_i;
            res_valid_q <= 1'b1;
            mm_en_q     <= 1'b0;
            state_q     <= HOLD;
          end
`ifdef MATMUL_FEEDER_TIMEOUT_EN
          else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            mm_en_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign mm_en_o     = mm_en_q;
  assign mm_valid_o  = mm_valid_q;
  assign mm_col_o    = mm_col_q;
  assign mm_elem_o   = mm_elem_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;

endmodule

// File: tb/tb_matmul_feeder.sv
// Scoreboard bench for matmul_feeder: reference matrix-vector model, array responder, monitor.
module tb_matmul_feeder;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst, wr_en, wr_sel, start, mm_valid_i, res_ready;
  logic [2:0]   wr_addr;
  logic [63:0]  wr_data;
  logic         busy_o, done_o, err_o, mm_en_o, mm_valid_o, res_valid_o;
  logic [63:0]  mm_col_o;
  logic [7:0]   mm_elem_o;
  logic [255:0] mm_result_i, res_data_o;

  always #5 clk = ~clk;

  matmul_feeder #(.N(8), .DW(8), .ACC_W(32), .TIMEOUT(64)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .start_i(start), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .mm_en_o(mm_en_o), .mm_valid_o(mm_valid_o), .mm_col_o(mm_col_o), .mm_elem_o(mm_elem_o),
    .mm_valid_i(mm_valid_i), .mm_result_i(mm_result_i), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready), .res_data_o(res_data_o)
  );

  int errors = 0;
  int checks = 0;

  logic [63:0]  exp_col_q [$];
  logic [7:0]   exp_elem_q [$];
  logic [255:0] exp_res_q [$];

  logic [63:0] ref_col [N];
  logic [63:0] ref_vec;

  bit model_on = 1'b1;
  int model_lat = 3;
  bit extra_req = 1'b0;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [255:0] exp_result();
    logic [255:0] r;
    logic [63:0]  c;
    int s;
    r = '0;
    for (int row = 0; row < N; row++) begin
      s = 0;
      for (int k = 0; k < N; k++) begin
        c = ref_col[k];
        s += int'($signed(c[row*8 +: 8])) * int'($signed(ref_vec[k*8 +: 8]));
      end
      r[row*32 +: 32] = s;
    end
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic push_expect(input bit with_res);
    for (int k = 0; k < N; k++) begin
      exp_col_q.push_back(ref_col[k]);
      exp_elem_q.push_back(ref_vec[k*8 +: 8]);
    end
    if (with_res) exp_res_q.push_back(exp_result());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_col(input int c, input logic [63:0] d);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'(c); wr_data = d;
    tick();
    wr_en = 1'b0;
    ref_col[c] = d;
  endtask

  task automatic wr_vec(input logic [63:0] d);
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 3'($urandom_range(0, 7)); wr_data = d;
    tick();
    wr_en = 1'b0;
    ref_vec = d;
  endtask

  task automatic clear_ref();
    for (int c = 0; c < N; c++) ref_col[c] = '0;
    ref_vec = '0;
  endtask

  // mode: 0 ready always high, 1 ready low for 5 HOLD cycles (+ stray result pulse), 2 random
  // noise: 0 quiet, 1 random start/writes while busy, 2 start + column-0 all-ones write while busy
  task automatic run(input int lat, input int mode, input int noise, input bit wr_at_start);
    logic [63:0] d;
    int hc;
    bit got;
    model_lat = lat;
    if (wr_at_start) begin
      d = rand64();
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = d;
      ref_col[0] = d;
    end
    push_expect(1'b1);
    start = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0;
    hc = 0; got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      case (mode)
        0: res_ready = 1'b1;
        1: res_ready = res_valid_o && hc >= 5;
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 1 && res_valid_o) begin
        if (hc == 2) extra_req = 1'b1;
        hc++;
      end
      if (noise == 1 && busy_o) begin
        start = 1'($urandom_range(0, 1)); wr_en = 1'($urandom_range(0, 1));
        wr_sel = 1'($urandom_range(0, 1)); wr_addr = 3'($urandom_range(0, 7)); wr_data = rand64();
      end else if (noise == 2 && busy_o) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = '1;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      tick();
      if (done_o) got = 1'b1;
    end
    start = 1'b0; wr_en = 1'b0;
    chk("run_done", 256'(got), 256'(1));
    res_ready = 1'b0;
  endtask

  // Array responder: accumulates the beats it actually receives, answers after model_lat cycles.
  initial begin
    int acc [N];
    int nb, cd;
    logic [255:0] pend;
    mm_valid_i = 1'b0; mm_result_i = '0; nb = 0; cd = -1; pend = '0;
    for (int r = 0; r < N; r++) acc[r] = 0;
    forever begin
      @(negedge clk);
      mm_valid_i = 1'b0;
      if (rst) begin
        nb = 0; cd = -1;
        for (int r = 0; r < N; r++) acc[r] = 0;
      end else if (mm_valid_o && mm_en_o) begin
        for (int r = 0; r < N; r++)
          acc[r] += int'($signed(mm_col_o[r*8 +: 8])) * int'($signed(mm_elem_o));
        nb++;
        if (nb == N) begin
          for (int r = 0; r < N; r++) begin pend[r*32 +: 32] = acc[r]; acc[r] = 0; end
          nb = 0; cd = model_lat;
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          if (model_on) begin mm_valid_i = 1'b1; mm_result_i = pend; end
          cd = -1;
        end
      end
      if (extra_req) begin
        mm_valid_i = 1'b1;
        for (int r = 0; r < N; r++) mm_result_i[r*32 +: 32] = $urandom;
        extra_req = 1'b0;
      end
    end
  end

  // Monitor: beats, results, done timing and HOLD stability.
  initial begin
    bit hs, hs_prev, hold_prev;
    logic [255:0] data_prev;
    hs_prev = 1'b0; hold_prev = 1'b0; data_prev = '0;
    forever begin
      @(negedge clk);
      if (mm_valid_o) begin
        chk("beat_expected", 256'(exp_col_q.size() != 0), 256'(1));
        if (exp_col_q.size() != 0) begin
          chk("beat_col", 256'(mm_col_o), 256'(exp_col_q.pop_front()));
          chk("beat_elem", 256'(mm_elem_o), 256'(exp_elem_q.pop_front()));
          chk("beat_en", 256'(mm_en_o), 256'(1));
        end
      end
      if (!rst) chk("done_timing", 256'(done_o), 256'(hs_prev));
      if (done_o) chk("busy_after_done", 256'(busy_o), 256'(0));
      if (hold_prev && !rst) begin
        chk("hold_valid", 256'(res_valid_o), 256'(1));
        chk("hold_data", res_data_o, data_prev);
      end
      hs = res_valid_o && res_ready;
      if (hs) begin
        chk("result_expected", 256'(exp_res_q.size() != 0), 256'(1));
        if (exp_res_q.size() != 0) chk("result_data", res_data_o, exp_res_q.pop_front());
      end
`ifndef MATMUL_FEEDER_TIMEOUT_EN
      chk("err_low", 256'(err_o), 256'(0));
`endif
      hs_prev   = hs && !rst;
      hold_prev = res_valid_o && !res_ready && !rst;
      data_prev = res_data_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 256'(busy_o), 256'(0));
    chk({tag, "_done"}, 256'(done_o), 256'(0));
    chk({tag, "_err"}, 256'(err_o), 256'(0));
    chk({tag, "_mm_en"}, 256'(mm_en_o), 256'(0));
    chk({tag, "_mm_valid"}, 256'(mm_valid_o), 256'(0));
    chk({tag, "_mm_col"}, 256'(mm_col_o), 256'(0));
    chk({tag, "_mm_elem"}, 256'(mm_elem_o), 256'(0));
    chk({tag, "_res_valid"}, 256'(res_valid_o), 256'(0));
    chk({tag, "_res_data"}, res_data_o, 256'(0));
  endtask

  initial begin
    logic [63:0] d;
    int at, nerr;
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; res_ready = 1'b0;
    clear_ref();
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // identity matrix, vector 1..8
    for (int k = 0; k < N; k++) begin
      d = '0; d[k*8 +: 8] = 8'd1;
      wr_col(k, d);
    end
    d = '0;
    for (int k = 0; k < N; k++) d[k*8 +: 8] = 8'(k + 1);
    wr_vec(d);
    run(3, 0, 0, 1'b0);
    for (int r = 0; r < N; r++) chk("identity_lane", 256'(res_data_o[r*32 +: 32]), 256'(r + 1));

    // all -128
    for (int k = 0; k < N; k++) wr_col(k, {8{8'h80}});
    wr_vec({8{8'h80}});
    run(2, 0, 0, 1'b0);
    for (int r = 0; r < N; r++) chk("neg128_lane", 256'(res_data_o[r*32 +: 32]), 256'(32'h0002_0000));

    // back-pressure with a stray result pulse during HOLD
    for (int k = 0; k < N; k++) wr_col(k, rand64());
    wr_vec(rand64());
    run(4, 1, 0, 1'b0);

    // start and column writes while busy are ignored; buffers persist for a rerun
    run(2, 0, 2, 1'b0);
    repeat (10) tick();
    run(5, 0, 0, 1'b0);

    // randomized runs
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 2) != 0) wr_col(k, rand64());
      if ($urandom_range(0, 1) != 0) wr_vec(rand64());
      run($urandom_range(1, 6), $urandom_range(0, 2), 1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) tick();
    end

    // reset during beat 4
    model_lat = 3;
    push_expect(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check_all_zero("midreset");
    rst = 1'b0;
    exp_col_q.delete(); exp_elem_q.delete();
    clear_ref();
    tick();
    run(3, 0, 0, 1'b0);
    chk("after_reset_zero", res_data_o, 256'(0));

    // array never answers
    model_on = 1'b0;
    push_expect(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    at = -1; nerr = 0;
    for (int i = 1; i <= 120; i++) begin
      if (err_o) begin
        nerr++;
        if (at < 0) begin
          at = i;
          chk("timeout_busy", 256'(busy_o), 256'(0));
          chk("timeout_mm_en", 256'(mm_en_o), 256'(0));
          chk("timeout_res_valid", 256'(res_valid_o), 256'(0));
          chk("timeout_done", 256'(done_o), 256'(0));
        end
      end
      tick();
    end
`ifdef MATMUL_FEEDER_TIMEOUT_EN
    chk("timeout_cycle", 256'(at), 256'(1 + N + 64));
    chk("timeout_pulses", 256'(nerr), 256'(1));
`else
    chk("no_timeout_pulses", 256'(nerr), 256'(0));
    chk("wait_persists_busy", 256'(busy_o), 256'(1));
    chk("wait_persists_en", 256'(mm_en_o), 256'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_ref();
`endif
    model_on = 1'b1;
    tick();
    run(2, 0, 0, 1'b0);

    repeat (10) tick();
    chk("beats_drained", 256'(exp_col_q.size()), 256'(0));
    chk("results_drained", 256'(exp_res_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
